// File: rtl/game_round_sequencer_if.sv
// Signal bundle between the game round sequencer and its surroundings
// (coin acceptor, master-pattern loader, guess grader).
// The optional grade_err signal exists only when GRADE_TIMEOUT_EN is defined.
//
// Handshake rules:
//   load_shape_now -> load_shape_en: each accepted pulse yields one write-enable pulse.
//   grade_req / grade_done: grade_req rises on guess submission and stays high
//   until grade_done is sampled high (or the optional watchdog expires).
//   grade_done is a 1-cycle pulse and is ignored unless a grade is outstanding.
interface game_round_sequencer_if;
  logic       coin_credit;
  logic       start_game;
  logic       load_shape_now;
  logic [1:0] shape_location;
  logic       grade_it;
  logic       grade_done;
  logic       game_won_in;
  logic [3:0] num_games;
  logic [3:0] round_number;
  logic       clear_game;
  logic       load_shape_en;
  logic [1:0] load_loc;
  logic       load_guess;
  logic       grade_req;
  logic       game_won;
  logic       game_over;
`ifdef GRADE_TIMEOUT_EN
  logic       grade_err;
`endif

  // Sequencer side
  modport master (
    input  coin_credit, start_game, load_shape_now, shape_location,
           grade_it, grade_done, game_won_in,
    output num_games, round_number, clear_game, load_shape_en, load_loc,
           load_guess, grade_req, game_won, game_over
`ifdef GRADE_TIMEOUT_EN
    , output grade_err
`endif
  );

  // Environment side
  modport slave (
    output coin_credit, start_game, load_shape_now, shape_location,
           grade_it, grade_done, game_won_in,
    input  num_games, round_number, clear_game, load_shape_en, load_loc,
           load_guess, grade_req, game_won, game_over
`ifdef GRADE_TIMEOUT_EN
    , input grade_err
`endif
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Top-level controller for the Mastermind-style game: banks credits, starts a
// game, sequences loading of the 4-slot master pattern, issues one grade
// request per guess, counts rounds and declares won/lost.
// Optional feature macro: GRADE_TIMEOUT_EN adds a grade watchdog and grade_err.
// Every output is a flop, so an event sampled at an edge shows up right after it.
module game_round_sequencer #(
  parameter int MAX_ROUNDS     = 8,
  parameter int MAX_CREDITS    = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  game_round_sequencer_if.master        bus,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GRADE = 3'd3,
    ST_WON   = 3'd4,
    ST_LOST  = 3'd5
  } state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
  localparam logic [3:0] MAX_C = 4'(MAX_CREDITS);

  // Elaboration-time range check of the configuration
  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 15 || MAX_CREDITS < 1 || MAX_CREDITS > 15 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("game_round_sequencer: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [3:0] num_games_q, num_games_d;
  logic [3:0] round_q, round_d;
  logic [3:0] mask_q, mask_d;
  logic       grade_it_prev_q, grade_it_prev_d;
  logic       clear_game_q, clear_game_d;
  logic       load_shape_en_q, load_shape_en_d;
  logic [1:0] load_loc_q, load_loc_d;
  logic       load_guess_q, load_guess_d;
  logic       grade_req_q, grade_req_d;
  logic       game_won_q, game_won_d;
  logic       game_over_q, game_over_d;

`ifdef GRADE_TIMEOUT_EN
  localparam int          TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            grade_err_q, grade_err_d;
`endif

  logic       submit;
  logic       start_ok;
  logic [3:0] round_inc;
  logic [3:0] mask_next;

  // Next-state, credit, round and output computation
  always_comb begin
    state_d         = state_q;
    num_games_d     = num_games_q;
    round_d         = round_q;
    mask_d          = mask_q;
    grade_it_prev_d = bus.grade_it;
    clear_game_d    = 1'b0;
    load_shape_en_d = 1'b0;
    load_loc_d      = load_loc_q;
    load_guess_d    = 1'b0;
    grade_req_d     = grade_req_q;
`ifdef GRADE_TIMEOUT_EN
    to_cnt_d        = to_cnt_q;
    grade_err_d     = 1'b0;
`endif

    // A guess is submitted only on the rising edge of the player's level
    submit    = bus.grade_it && !grade_it_prev_q;
    round_inc = round_q + 4'd1;
    mask_next = mask_q | (4'b0001 << bus.shape_location);
    start_ok  = (state_q == ST_IDLE || state_q == ST_WON || state_q == ST_LOST) &&
                bus.start_game && (num_games_q != 4'd0);

    // A start consumes one credit; a coin in the same cycle refills it, which
    // also keeps a saturated counter at MAX_C without overflowing.
    if (start_ok) begin
      num_games_d = num_games_q - 4'd1 + {3'd0, bus.coin_credit};
    end else if (bus.coin_credit && num_games_q < MAX_C) begin
      num_games_d = num_games_q + 4'd1;
    end

    unique case (state_q)
      ST_IDLE, ST_WON, ST_LOST: begin
        if (start_ok) begin
          state_d      = ST_LOAD;
          clear_game_d = 1'b1;
          round_d      = 4'd0;
          mask_d       = 4'd0;
        end
      end
      ST_LOAD: begin
        if (bus.load_shape_now) begin
          load_shape_en_d = 1'b1;
          load_loc_d      = bus.shape_location;
          mask_d          = mask_next;
          if (mask_next == 4'hF) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (submit) begin
          load_guess_d = 1'b1;
          grade_req_d  = 1'b1;
          state_d      = ST_GRADE;
`ifdef GRADE_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end
      end
      ST_GRADE: begin
        if (bus.grade_done) begin
          grade_req_d = 1'b0;
          round_d     = round_inc;
          if (bus.game_won_in)       state_d = ST_WON;
          else if (round_inc == MAX_R) state_d = ST_LOST;
          else                       state_d = ST_PLAY;
        end
`ifdef GRADE_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          grade_req_d = 1'b0;
          grade_err_d = 1'b1;
          state_d     = ST_PLAY;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    game_won_d  = (state_d == ST_WON);
    game_over_d = (state_d == ST_WON) || (state_d == ST_LOST);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      num_games_q     <= 4'd0;
      round_q         <= 4'd0;
      mask_q          <= 4'd0;
      grade_it_prev_q <= 1'b0;
      clear_game_q    <= 1'b0;
      load_shape_en_q <= 1'b0;
      load_loc_q      <= 2'd0;
      load_guess_q    <= 1'b0;
      grade_req_q     <= 1'b0;
      game_won_q      <= 1'b0;
      game_over_q     <= 1'b0;
`ifdef GRADE_TIMEOUT_EN
      to_cnt_q        <= '0;
      grade_err_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      num_games_q     <= num_games_d;
      round_q         <= round_d;
      mask_q          <= mask_d;
      grade_it_prev_q <= grade_it_prev_d;
      clear_game_q    <= clear_game_d;
      load_shape_en_q <= load_shape_en_d;
      load_loc_q      <= load_loc_d;
      load_guess_q    <= load_guess_d;
      grade_req_q     <= grade_req_d;
      game_won_q      <= game_won_d;
      game_over_q     <= game_over_d;
`ifdef GRADE_TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
      grade_err_q     <= grade_err_d;
`endif
    end
  end

  assign bus.num_games     = num_games_q;
  assign bus.round_number  = round_q;
  assign bus.clear_game    = clear_game_q;
  assign bus.load_shape_en = load_shape_en_q;
  assign bus.load_loc      = load_loc_q;
  assign bus.load_guess    = load_guess_q;
  assign bus.grade_req     = grade_req_q;
  assign bus.game_won      = game_won_q;
  assign bus.game_over     = game_over_q;
`ifdef GRADE_TIMEOUT_EN
  assign bus.grade_err     = grade_err_q;
`endif
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed testbench for game_round_sequencer (MAX_ROUNDS=8, MAX_CREDITS=7).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_game_round_sequencer;

  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_GRADE = 3;
  localparam int ST_WON   = 4;
  localparam int ST_LOST  = 5;

  logic       clock;
  logic       reset_n;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_errors;

  game_round_sequencer_if bus ();

  game_round_sequencer #(
    .MAX_ROUNDS    (8),
    .MAX_CREDITS   (7),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Clock and global time limit
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: got simulation still running expected finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Load all four slots in order; PLAY follows the last one
  task automatic load_all();
    for (int s = 0; s < 4; s++) begin
      bus.load_shape_now = 1'b1;
      bus.shape_location = 2'(s);
      tick();
      bus.load_shape_now = 1'b0;
      check("load_all_en", bus.load_shape_en, 1);
      check("load_all_loc", bus.load_loc, s);
    end
    check("load_all_state", dbg_state, ST_PLAY);
  endtask

  // Submit one guess, then answer with grade_done on the next cycle
  task automatic grade_round(input bit won, input int exp_round, input int exp_state);
    bus.grade_it = 1'b1;
    tick();
    bus.grade_it = 1'b0;
    check("round_load_guess", bus.load_guess, 1);
    check("round_req_set", bus.grade_req, 1);
    check("round_in_grade", dbg_state, ST_GRADE);
    bus.grade_done  = 1'b1;
    bus.game_won_in = won;
    tick();
    bus.grade_done  = 1'b0;
    bus.game_won_in = 1'b0;
    check("round_req_clr", bus.grade_req, 0);
    check("round_number", bus.round_number, exp_round);
    check("round_next_state", dbg_state, exp_state);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n             = 1'b0;
    bus.coin_credit     = 1'b0;
    bus.start_game      = 1'b0;
    bus.load_shape_now  = 1'b0;
    bus.shape_location  = 2'd0;
    bus.grade_it        = 1'b0;
    bus.grade_done      = 1'b0;
    bus.game_won_in     = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_num_games", bus.num_games, 0);
    check("rst_round", bus.round_number, 0);
    check("rst_grade_req", bus.grade_req, 0);
    check("rst_game_over", bus.game_over, 0);
    reset_n = 1'b1;
    tick();

    // Start with no credits does nothing
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("start_no_credit_state", dbg_state, ST_IDLE);
    check("start_no_credit_clear", bus.clear_game, 0);

    // Three coins then start
    for (int i = 1; i <= 3; i++) begin
      bus.coin_credit = 1'b1;
      tick();
      bus.coin_credit = 1'b0;
      check("coin_count", bus.num_games, i);
    end
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("start_clear", bus.clear_game, 1);
    check("start_num_games", bus.num_games, 2);
    check("start_state", dbg_state, ST_LOAD);
    tick();
    check("clear_is_pulse", bus.clear_game, 0);

    // Submission in LOAD is ignored
    bus.grade_it = 1'b1;
    tick();
    bus.grade_it = 1'b0;
    check("load_ignores_guess", bus.load_guess, 0);
    check("load_ignores_guess_state", dbg_state, ST_LOAD);
    tick();

    // Slots 0,1,1,2,3 with an idle cycle between loads
    begin
      logic [1:0] slots [5];
      slots = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      for (int i = 0; i < 5; i++) begin
        bus.load_shape_now = 1'b1;
        bus.shape_location = slots[i];
        tick();
        bus.load_shape_now = 1'b0;
        check("load_en", bus.load_shape_en, 1);
        check("load_loc", bus.load_loc, slots[i]);
        check("load_state", dbg_state, (i == 4) ? ST_PLAY : ST_LOAD);
        tick();
        check("load_en_pulse", bus.load_shape_en, 0);
      end
    end

    // load_shape_now in PLAY is ignored
    bus.load_shape_now = 1'b1;
    bus.shape_location = 2'd2;
    tick();
    bus.load_shape_now = 1'b0;
    check("play_ignores_load", bus.load_shape_en, 0);

    // Hold grade_it 5 cycles: one load_guess; grade_done 4 cycles after submission
    bus.grade_it = 1'b1;
    tick();
    check("hold_first_guess", bus.load_guess, 1);
    check("hold_req", bus.grade_req, 1);
    check("hold_state", dbg_state, ST_GRADE);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("hold_no_reguess", bus.load_guess, 0);
      check("hold_req_held", bus.grade_req, 1);
    end
    bus.grade_done = 1'b1;
    tick();
    bus.grade_done = 1'b0;
    check("hold_done_req", bus.grade_req, 0);
    check("hold_done_round", bus.round_number, 1);
    check("hold_done_state", dbg_state, ST_PLAY);
    check("hold_done_no_guess", bus.load_guess, 0);
    bus.grade_it = 1'b0;
    tick();

    // Stray grade_done in PLAY
    bus.grade_done  = 1'b1;
    bus.game_won_in = 1'b1;
    tick();
    bus.grade_done  = 1'b0;
    bus.game_won_in = 1'b0;
    check("stray_done_round", bus.round_number, 1);
    check("stray_done_state", dbg_state, ST_PLAY);
    check("stray_done_won", bus.game_won, 0);

    // Rounds 2..8 lost -> LOST at round 8
    for (int r = 2; r <= 8; r++) grade_round(1'b0, r, (r == 8) ? ST_LOST : ST_PLAY);
    check("lost_over", bus.game_over, 1);
    check("lost_won", bus.game_won, 0);

    // New game from LOST, win on round 3
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("restart_num", bus.num_games, 1);
    check("restart_round", bus.round_number, 0);
    check("restart_over", bus.game_over, 0);
    load_all();
    grade_round(1'b0, 1, ST_PLAY);
    grade_round(1'b0, 2, ST_PLAY);
    grade_round(1'b1, 3, ST_WON);
    check("won_flag", bus.game_won, 1);
    check("won_over", bus.game_over, 1);
    tick();
    check("won_hold_round", bus.round_number, 3);

    // Coin together with start: credits unchanged
    bus.coin_credit = 1'b1;
    bus.start_game  = 1'b1;
    tick();
    bus.coin_credit = 1'b0;
    bus.start_game  = 1'b0;
    check("coin_start_num", bus.num_games, 1);
    check("coin_start_state", dbg_state, ST_LOAD);
    check("coin_start_clear", bus.clear_game, 1);

    // Win on round 1, then spend the last credit
    load_all();
    grade_round(1'b1, 1, ST_WON);
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("last_credit_num", bus.num_games, 0);

    // Win on the final round counts as WON
    load_all();
    for (int r = 1; r <= 7; r++) grade_round(1'b0, r, ST_PLAY);
    grade_round(1'b1, 8, ST_WON);
    check("final_win_flag", bus.game_won, 1);

    // Start with no credits stays in WON
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("no_credit_state", dbg_state, ST_WON);
    check("no_credit_clear", bus.clear_game, 0);

    // Credit saturation, then coin+start at saturation
    for (int i = 1; i <= 8; i++) begin
      bus.coin_credit = 1'b1;
      tick();
      bus.coin_credit = 1'b0;
      check("sat_coin", bus.num_games, (i > 7) ? 7 : i);
    end
    bus.coin_credit = 1'b1;
    bus.start_game  = 1'b1;
    tick();
    bus.coin_credit = 1'b0;
    bus.start_game  = 1'b0;
    check("sat_coin_start_num", bus.num_games, 7);
    check("sat_coin_start_state", dbg_state, ST_LOAD);
    load_all();

`ifdef GRADE_TIMEOUT_EN
    // Watchdog: 16 cycles in GRADE without grade_done
    bus.grade_it = 1'b1;
    tick();
    bus.grade_it = 1'b0;
    check("to_enter", dbg_state, ST_GRADE);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("to_req_held", bus.grade_req, 1);
      check("to_no_err", bus.grade_err, 0);
    end
    tick();
    check("to_err", bus.grade_err, 1);
    check("to_req_clr", bus.grade_req, 0);
    check("to_state", dbg_state, ST_PLAY);
    check("to_round", bus.round_number, 0);
    tick();
    check("to_err_pulse", bus.grade_err, 0);
`endif

    // Reset during GRADE
    bus.grade_it = 1'b1;
    tick();
    bus.grade_it = 1'b0;
    check("pre_rst_grade", dbg_state, ST_GRADE);
    reset_n = 1'b0;
    tick();
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_req", bus.grade_req, 0);
    check("mid_rst_num", bus.num_games, 0);
    check("mid_rst_round", bus.round_number, 0);
    check("mid_rst_over", bus.game_over, 0);
    check("mid_rst_loc", bus.load_loc, 0);
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
